// File: rtl/poc_arbiter.sv
// Two-requester arbiter sharing one POC peripheral; round-robin on ties,
// one-cycle RELEASE turnaround. Optional grant timeout: POC_ARB_TIMEOUT_EN.
//
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_req0/1 -> o_gnt0/1            request / registered grant
//   i_din0/1, i_addr0/1, i_rw0/1    per-requester POC access fields
//   o_dout0/1, o_irq0_n/o_irq1_n    POC read data / irq, granted side only
//   o_poc_din/addr/rw               muxed access to the POC
//   i_poc_dout, i_poc_irq_n         POC read data / irq
//   o_timeout                       pulse in the final cycle of a forced grant
module poc_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req0,
  input  logic       i_req1,
  output logic       o_gnt0,
  output logic       o_gnt1,
  input  logic [7:0] i_din0,
  input  logic [7:0] i_din1,
  input  logic       i_addr0,
  input  logic       i_addr1,
  input  logic       i_rw0,
  input  logic       i_rw1,
  output logic [7:0] o_dout0,
  output logic [7:0] o_dout1,
  output logic       o_irq0_n,
  output logic       o_irq1_n,
  output logic [7:0] o_poc_din,
  output logic       o_poc_addr,
  output logic       o_poc_rw,
  input  logic [7:0] i_poc_dout,
  input  logic       i_poc_irq_n,
  output logic       o_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1,
    RELEASE
  } state_e;

  state_e state_q, state_d;
  logic   lg_q, lg_d;

`ifdef POC_ARB_TIMEOUT_EN
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       to_hit;
`else
  logic [7:0] unused_to;
  assign unused_to = 8'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d = state_q;
    lg_d    = lg_q;
`ifdef POC_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_hit  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef POC_ARB_TIMEOUT_EN
        cnt_d = 8'd0;
`endif
        // lg_q = 1 means requester 1 went last, so 0 wins a tie
        if (i_req0 && (!i_req1 || lg_q)) begin
          state_d = GRANT0;
          lg_d    = 1'b0;
        end else if (i_req1) begin
          state_d = GRANT1;
          lg_d    = 1'b1;
        end
      end
      GRANT0: begin
        if (!i_req0) begin
          state_d = RELEASE;
`ifdef POC_ARB_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          state_d = RELEASE;
          to_hit  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      GRANT1: begin
        if (!i_req1) begin
          state_d = RELEASE;
`ifdef POC_ARB_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          state_d = RELEASE;
          to_hit  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      lg_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      lg_q    <= lg_d;
    end
  end

`ifdef POC_ARB_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= 8'd0;
    else          cnt_q <= cnt_d;
  end
  assign o_timeout = to_hit;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_gnt0 = (state_q == GRANT0);
  assign o_gnt1 = (state_q == GRANT1);

  always_comb begin
    o_poc_din  = 8'h00;
    o_poc_addr = 1'b0;
    o_poc_rw   = 1'b0;
    unique case (1'b1)
      o_gnt0: begin
        o_poc_din  = i_din0;
        o_poc_addr = i_addr0;
        o_poc_rw   = i_rw0;
      end
      o_gnt1: begin
        o_poc_din  = i_din1;
        o_poc_addr = i_addr1;
        o_poc_rw   = i_rw1;
      end
      default: ;
    endcase
  end

  assign o_dout0  = o_gnt0 ? i_poc_dout : 8'h00;
  assign o_dout1  = o_gnt1 ? i_poc_dout : 8'h00;
  assign o_irq0_n = o_gnt0 ? i_poc_irq_n : 1'b1;
  assign o_irq1_n = o_gnt1 ? i_poc_irq_n : 1'b1;

endmodule

// File: tb/tb_poc_arbiter.sv
// Bench for poc_arbiter: directed literal checks plus randomized traffic
// compared every cycle against a transaction-level model of the bus owner.
module tb_poc_arbiter;

  localparam int TO = 4;
`ifdef POC_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0 = 0, req1 = 0;
  logic       gnt0, gnt1;
  logic [7:0] din0 = 0, din1 = 0;
  logic       addr0 = 0, addr1 = 0;
  logic       rw0 = 0, rw1 = 0;
  logic [7:0] dout0, dout1;
  logic       irq0_n, irq1_n;
  logic [7:0] poc_din;
  logic       poc_addr, poc_rw;
  logic [7:0] poc_dout = 0;
  logic       poc_irq_n = 1;
  logic       timeout;

  int nvec = 0;
  int nerr = 0;

  poc_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_req1(req1),
    .o_gnt0(gnt0), .o_gnt1(gnt1),
    .i_din0(din0), .i_din1(din1),
    .i_addr0(addr0), .i_addr1(addr1),
    .i_rw0(rw0), .i_rw1(rw1),
    .o_dout0(dout0), .o_dout1(dout1),
    .o_irq0_n(irq0_n), .o_irq1_n(irq1_n),
    .o_poc_din(poc_din), .o_poc_addr(poc_addr), .o_poc_rw(poc_rw),
    .i_poc_dout(poc_dout), .i_poc_irq_n(poc_irq_n),
    .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  // Model: who owns the bus (-1 none), whether the turnaround cycle is
  // running, who was granted last, and how long the owner has held it.
  int m_own  = -1;
  bit m_turn = 0;
  int m_last = 1;
  int m_cnt  = 0;

  function automatic bit own_req();
    return (m_own == 0) ? req0 : req1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own = -1; m_turn = 0; m_last = 1; m_cnt = 0;
    end else if (m_own >= 0) begin
      if (!own_req() || (TO_EN && m_cnt == TO - 1)) begin
        m_own = -1; m_turn = 1;
      end else begin
        m_cnt++;
      end
    end else if (m_turn) begin
      m_turn = 0;
    end else begin
      if (req0 && req1) m_own = 1 - m_last;
      else if (req0)    m_own = 0;
      else if (req1)    m_own = 1;
      if (m_own >= 0) begin
        m_last = m_own;
        m_cnt  = 0;
      end
    end
  end

  task automatic chk(input string n, input logic [7:0] a,
                     input logic [7:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e_din;
    logic       e_addr, e_rw, e_to;
    e_din  = (m_own == 0) ? din0 : (m_own == 1) ? din1 : 8'h00;
    e_addr = (m_own == 0) ? addr0 : (m_own == 1) ? addr1 : 1'b0;
    e_rw   = (m_own == 0) ? rw0 : (m_own == 1) ? rw1 : 1'b0;
    e_to   = TO_EN && m_own >= 0 && own_req() && m_cnt == TO - 1;
    chk("gnt0", 8'(gnt0), 8'(m_own == 0));
    chk("gnt1", 8'(gnt1), 8'(m_own == 1));
    chk("poc_din", poc_din, e_din);
    chk("poc_addr", 8'(poc_addr), 8'(e_addr));
    chk("poc_rw", 8'(poc_rw), 8'(e_rw));
    chk("dout0", dout0, (m_own == 0) ? poc_dout : 8'h00);
    chk("dout1", dout1, (m_own == 1) ? poc_dout : 8'h00);
    chk("irq0_n", 8'(irq0_n), 8'((m_own == 0) ? poc_irq_n : 1'b1));
    chk("irq1_n", 8'(irq1_n), 8'((m_own == 1) ? poc_irq_n : 1'b1));
    chk("timeout", 8'(timeout), 8'(e_to));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_gnt0", 8'(gnt0), 8'd0);
    chk("rst_gnt1", 8'(gnt1), 8'd0);
    chk("rst_timeout", 8'(timeout), 8'd0);
    chk("rst_poc_din", poc_din, 8'h00);
    chk("rst_irq0_n", 8'(irq0_n), 8'd1);
    rst_n = 1'b1;

    // single request, one-cycle grant latency, POC mux
    req0 = 1; din0 = 8'hA5; addr0 = 1; rw0 = 1;
    chk("lat_gnt0_c0", 8'(gnt0), 8'd0);
    tick();
    chk("lat_gnt0_c1", 8'(gnt0), 8'd1);
    chk("mux_din", poc_din, 8'hA5);
    chk("mux_addr", 8'(poc_addr), 8'd1);
    chk("mux_rw", 8'(poc_rw), 8'd1);
    req0 = 0; din0 = 0; addr0 = 0; rw0 = 0;
    tick();
    tick();

    // tie alternation with turnaround; irq/dout routing in GRANT1
    do_reset();
    req0 = 1; req1 = 1;
    tick();
    chk("rr_g0_a", 8'({gnt1, gnt0}), 8'b01);
    req0 = 0;
    tick();
    chk("rr_rel_a", 8'({gnt1, gnt0}), 8'b00);
    req0 = 1;
    poc_irq_n = 0; poc_dout = 8'h81;
    tick();
    chk("rr_idle_a", 8'({gnt1, gnt0}), 8'b00);
    tick();
    chk("rr_g1", 8'({gnt1, gnt0}), 8'b10);
    chk("irq1_n_lit", 8'(irq1_n), 8'd0);
    chk("dout1_lit", dout1, 8'h81);
    chk("irq0_n_lit", 8'(irq0_n), 8'd1);
    chk("dout0_lit", dout0, 8'h00);
    poc_irq_n = 1; poc_dout = 0;
    req1 = 0;
    tick();
    chk("rr_rel_b", 8'({gnt1, gnt0}), 8'b00);
    req1 = 1;
    tick();
    tick();
    chk("rr_g0_b", 8'({gnt1, gnt0}), 8'b01);

    // async reset mid-grant
    rw0 = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt0", 8'(gnt0), 8'd0);
    chk("arst_rw", 8'(poc_rw), 8'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_tie_g0", 8'({gnt1, gnt0}), 8'b01);
    rw0 = 0; req0 = 0; req1 = 0;
    tick();
    tick();

`ifdef POC_ARB_TIMEOUT_EN
    do_reset();
    req0 = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_gnt0", 8'(gnt0), 8'd1);
      chk("to_pulse", 8'(timeout), 8'(i == 3));
    end
    req1 = 1;
    tick();
    chk("to_rel", 8'({gnt1, gnt0}), 8'b00);
    tick();
    tick();
    chk("to_loser", 8'({gnt1, gnt0}), 8'b10);
    req0 = 0; req1 = 0;
    tick();
    tick();
`else
    do_reset();
    req0 = 1;
    repeat (100) tick();
    chk("nolimit_gnt0", 8'(gnt0), 8'd1);
    chk("nolimit_to", 8'(timeout), 8'd0);
    req0 = 0;
    tick();
    tick();
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      tick();
      req0 = ($urandom_range(0, 9) < ((m_own == 0) ? 8 : 5));
      req1 = ($urandom_range(0, 9) < ((m_own == 1) ? 8 : 5));
      din0 = 8'($urandom);
      din1 = 8'($urandom);
      addr0 = 1'($urandom);
      addr1 = 1'($urandom);
      rw0 = 1'($urandom);
      rw1 = 1'($urandom);
      poc_dout = 8'($urandom);
      poc_irq_n = 1'($urandom);
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
